// File: rtl/wave_mem_reader_if.sv
// -----------------------------------------------------------------------------
// wave_mem_reader_if
// Bundles the sample-RAM read port and the output sample stream of the
// waveform memory reader.
//
// Signals:
//   rd          read enable towards the RAM
//   raddr       RAM read address
//   rdata       RAM read data, valid a fixed number of cycles after rd
//   dout        output sample
//   dout_valid  output sample valid
//   dout_ready  downstream accept; transfer when dout_valid && dout_ready
//
// Modports:
//   master  reader side (drives rd/raddr/dout/dout_valid)
//   slave   RAM + downstream side (drives rdata/dout_ready)
// -----------------------------------------------------------------------------
interface wave_mem_reader_if #(
    parameter int p_nbit_d = 8,
    parameter int p_nbit_a = 4
) ();
    logic                rd;
    logic [p_nbit_a-1:0] raddr;
    logic [p_nbit_d-1:0] rdata;
    logic [p_nbit_d-1:0] dout;
    logic                dout_valid;
    logic                dout_ready;

    modport master (
        output rd, raddr, dout, dout_valid,
        input  rdata, dout_ready
    );

    modport slave (
        input  rd, raddr, dout, dout_valid,
        output rdata, dout_ready
    );
endinterface

// File: rtl/wave_mem_reader.sv
// -----------------------------------------------------------------------------
// wave_mem_reader
// Sequential read engine for the waveform sample RAM. After a start it reads
// len words from base_addr (address wraps modulo RAM depth), optionally
// repeating the pass until stop, absorbs the RAM read latency and delivers the
// samples as a valid/ready stream without loss or duplication.
//
// Parameters:
//   p_nbit_d      sample width
//   p_nbit_a      RAM address width (depth 2**p_nbit_a)
//   p_rd_latency  rd -> rdata latency, 1 or 2
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start_i       start pulse, accepted only when idle
//   stop_i        abort pulse, honoured when not idle (wins over start)
//   base_addr_i   first address, sampled on accepted start
//   len_i         words per pass (0..2**p_nbit_a), sampled on accepted start
//   loop_en_i     repeat passes until stop, sampled on accepted start
//   busy_o        high while running or draining
//   done_o        pulse on the final transfer of a non-looping pass, or one
//                 cycle after a zero-length start
//   bus           RAM read port + output stream (master side)
// -----------------------------------------------------------------------------
module wave_mem_reader #(
    parameter int p_nbit_d     = 8,
    parameter int p_nbit_a     = 4,
    parameter int p_rd_latency = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic [p_nbit_a-1:0] base_addr_i,
    input  logic [p_nbit_a:0]   len_i,
    input  logic                loop_en_i,
    output logic                busy_o,
    output logic                done_o,
    wave_mem_reader_if.master   bus
);

    localparam int DEPTH = p_rd_latency + 1;
    localparam int CNT_W = 3;
    localparam int PTR_W = 2;

    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [p_nbit_a:0]   REM_ONE  = (p_nbit_a+1)'(1);
    localparam logic [p_nbit_a-1:0] ADDR_ONE = p_nbit_a'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [p_nbit_a-1:0]     addr_q, addr_d;
    logic [p_nbit_a:0]       rem_q, rem_d;
    logic [p_nbit_a-1:0]     base_q, base_d;
    logic [p_nbit_a:0]       len_q, len_d;
    logic                    loop_q, loop_d;
    logic                    zlen_q, zlen_d;
    logic [p_rd_latency-1:0] tag_q, tag_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PTR_W-1:0]        wptr_q, wptr_d;
    logic [PTR_W-1:0]        rptr_q, rptr_d;
    logic [p_nbit_d-1:0]     buf_q [DEPTH];

    logic [CNT_W-1:0]        inflight;
    logic [CNT_W-1:0]        occ;
    logic                    tag_exit;
    logic                    buf_empty;
    logic                    dv;
    logic                    xfer;
    logic                    push;
    logic                    pop;
    logic                    issue;
    logic                    last_xfer;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < p_rd_latency; i++) begin
            inflight = inflight + CNT_W'(tag_q[i]);
        end
    end

    assign occ       = inflight + cnt_q;
    assign tag_exit  = tag_q[p_rd_latency-1];
    assign buf_empty = (cnt_q == '0);

    // The buffer is fall-through: when it is empty the word leaving the
    // latency pipeline is presented directly, which gives the
    // p_rd_latency+1 first-word latency and lets a word that is accepted
    // on arrival bypass storage entirely.
    assign dv        = !buf_empty || tag_exit;
    assign xfer      = dv && bus.dout_ready;
    assign push      = tag_exit && !(buf_empty && bus.dout_ready);
    assign pop       = !buf_empty && bus.dout_ready;

    // Credit rule: words in flight plus words buffered never exceed DEPTH,
    // so every returning word has a buffer slot.
    assign issue     = (state_q == S_RUN) && (rem_q != '0) && (occ < DEPTH_C);

    // occ == 1 during a transfer means this is the last outstanding word.
    assign last_xfer = (state_q == S_DRAIN) && xfer && (occ == CNT_ONE) && !stop_i;

    assign bus.rd         = issue;
    assign bus.raddr      = addr_q;
    assign bus.dout_valid = dv;
    assign bus.dout       = !dv ? '0 : (buf_empty ? bus.rdata : buf_q[rptr_q]);
    assign busy_o         = (state_q != S_IDLE);
    assign done_o         = last_xfer || zlen_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        base_d  = base_q;
        len_d   = len_q;
        loop_d  = loop_q;
        zlen_d  = 1'b0;
        cnt_d   = cnt_q;
        wptr_d  = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d  = pop  ? ptr_inc(rptr_q) : rptr_q;

        tag_d    = tag_q;
        tag_d[0] = issue;
        for (int i = 1; i < p_rd_latency; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        if (push && !pop) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_ONE;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (len_i == '0) begin
                        zlen_d = 1'b1;
                    end else begin
                        base_d  = base_addr_i;
                        len_d   = len_i;
                        loop_d  = loop_en_i;
                        addr_d  = base_addr_i;
                        rem_d   = len_i;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (issue) begin
                    addr_d = addr_q + ADDR_ONE;
                    if (rem_q == REM_ONE) begin
                        // Reload in the same cycle so looping has no bubble.
                        if (loop_q) begin
                            addr_d = base_q;
                            rem_d  = len_q;
                        end else begin
                            rem_d   = '0;
                            state_d = S_DRAIN;
                        end
                    end else begin
                        rem_d = rem_q - REM_ONE;
                    end
                end
            end
            S_DRAIN: begin
                if (last_xfer) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort discards everything outstanding; late rdata is ignored
        // because its tag is gone.
        if (stop_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            rem_d   = '0;
            tag_d   = '0;
            cnt_d   = '0;
            wptr_d  = '0;
            rptr_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            base_q  <= '0;
            len_q   <= '0;
            loop_q  <= 1'b0;
            zlen_q  <= 1'b0;
            tag_q   <= '0;
            cnt_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            base_q  <= base_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
            zlen_q  <= zlen_d;
            tag_q   <= tag_d;
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[wptr_q] <= bus.rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop && (cnt_q == DEPTH_C)));
        end
    end

endmodule

// File: tb/tb_wave_mem_reader.sv
// -----------------------------------------------------------------------------
// tb_wave_mem_reader
// Directed bench for wave_mem_reader with p_nbit_d=8, p_nbit_a=4,
// p_rd_latency=2. A registered two-stage RAM model supplies rdata. Each
// scenario runs a fixed number of cycles, logging outputs once per cycle
// (cycle 0 = the start cycle), then compares the log against hand-derived
// expectations.
// -----------------------------------------------------------------------------
module tb_wave_mem_reader;

    localparam int NB_D = 8;
    localparam int NB_A = 4;
    localparam int LAT  = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic            loop_en = 1'b0;
    logic [NB_A-1:0] base_addr = '0;
    logic [NB_A:0]   len = '0;
    logic            busy;
    logic            done;

    int errors = 0;
    int checks = 0;

    wave_mem_reader_if #(.p_nbit_d(NB_D), .p_nbit_a(NB_A)) bus ();

    wave_mem_reader #(
        .p_nbit_d     (NB_D),
        .p_nbit_a     (NB_A),
        .p_rd_latency (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .stop_i      (stop),
        .base_addr_i (base_addr),
        .len_i       (len),
        .loop_en_i   (loop_en),
        .busy_o      (busy),
        .done_o      (done),
        .bus         (bus.master)
    );

    always #5 clk = ~clk;

    // RAM model with registered output: data appears two cycles after rd.
    logic [NB_D-1:0] ram [16];
    logic [NB_D-1:0] r1 = '0;
    logic [NB_D-1:0] r2 = '0;
    always @(posedge clk) begin
        if (bus.rd) r1 <= ram[bus.raddr];
        r2 <= r1;
    end
    assign bus.rdata = r2;

    logic            lg_rd   [32];
    logic [NB_A-1:0] lg_addr [32];
    logic            lg_dv   [32];
    logic [NB_D-1:0] lg_dout [32];
    logic            lg_done [32];
    logic            lg_busy [32];
    logic            lg_rdy  [32];
    logic [NB_D-1:0] xq [$];
    logic [NB_A-1:0] aq [$];

    // Cycle 0 carries the start pulse; ready is low for cycles in
    // [stall_from, stall_to); stop pulses at stop_at; a second start pulse
    // at restart_at.
    task automatic run(input int n, input int stall_from, input int stall_to,
                       input int stop_at, input int restart_at);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            start          = (c == 0) || (c == restart_at);
            stop           = (c == stop_at);
            bus.dout_ready = !(c >= stall_from && c < stall_to);
            #1;
            lg_rd[c]   = bus.rd;
            lg_addr[c] = bus.raddr;
            lg_dv[c]   = bus.dout_valid;
            lg_dout[c] = bus.dout;
            lg_done[c] = done;
            lg_busy[c] = busy;
            lg_rdy[c]  = bus.dout_ready;
        end
        start          = 1'b0;
        stop           = 1'b0;
        bus.dout_ready = 1'b1;
        xq.delete();
        aq.delete();
        for (int c = 0; c < n; c++) begin
            if (lg_rd[c]) aq.push_back(lg_addr[c]);
            if (lg_dv[c] && lg_rdy[c]) xq.push_back(lg_dout[c]);
        end
    endtask

    task automatic test_reset();
        #2;
        checks += 6;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        if (bus.rd !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b expected 0", bus.rd); end
        if (bus.raddr !== 4'h0) begin errors++; $display("FAIL reset_raddr: got %h expected 0", bus.raddr); end
        if (bus.dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", bus.dout); end
        if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b expected 0", bus.dout_valid); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic            e_rd, e_dv, e_done, e_busy;
        logic [NB_D-1:0] e_dout;
        base_addr = 4'd3; len = 5'd4; loop_en = 1'b0;
        run(9, -1, -1, -1, -1);
        for (int c = 0; c < 9; c++) begin
            e_rd   = (c >= 1 && c <= 4);
            e_dv   = (c >= 3 && c <= 6);
            e_done = (c == 6);
            e_busy = (c >= 1 && c <= 6);
            e_dout = 8'hA0 + 8'(c - 3);
            checks += 4;
            if (lg_rd[c] !== e_rd) begin errors++; $display("FAIL basic_rd c%0d: got %b expected %b", c, lg_rd[c], e_rd); end
            if (lg_dv[c] !== e_dv) begin errors++; $display("FAIL basic_dv c%0d: got %b expected %b", c, lg_dv[c], e_dv); end
            if (lg_done[c] !== e_done) begin errors++; $display("FAIL basic_done c%0d: got %b expected %b", c, lg_done[c], e_done); end
            if (lg_busy[c] !== e_busy) begin errors++; $display("FAIL basic_busy c%0d: got %b expected %b", c, lg_busy[c], e_busy); end
            if (e_rd) begin
                checks++;
                if (lg_addr[c] !== 4'(c + 2)) begin errors++; $display("FAIL basic_raddr c%0d: got %0d expected %0d", c, lg_addr[c], c + 2); end
            end
            if (e_dv) begin
                checks++;
                if (lg_dout[c] !== e_dout) begin errors++; $display("FAIL basic_dout c%0d: got %h expected %h", c, lg_dout[c], e_dout); end
            end
        end
    endtask

    // Also pulses start again mid-run, which must be ignored.
    task automatic test_wrap();
        logic [NB_A-1:0] ea [4];
        logic [NB_D-1:0] ed [4];
        ea = '{4'd14, 4'd15, 4'd0, 4'd1};
        ed = '{8'hCE, 8'hCF, 8'hC0, 8'hC1};
        base_addr = 4'd14; len = 5'd4; loop_en = 1'b0;
        run(9, -1, -1, -1, 2);
        checks += 3;
        if (aq.size() != 4) begin errors++; $display("FAIL wrap_nreads: got %0d expected 4", aq.size()); end
        if (xq.size() != 4) begin errors++; $display("FAIL wrap_nwords: got %0d expected 4", xq.size()); end
        if (lg_done[6] !== 1'b1) begin errors++; $display("FAIL wrap_done: got %b expected 1", lg_done[6]); end
        for (int i = 0; i < 4 && i < aq.size(); i++) begin
            checks++;
            if (aq[i] !== ea[i]) begin errors++; $display("FAIL wrap_raddr %0d: got %0d expected %0d", i, aq[i], ea[i]); end
        end
        for (int i = 0; i < 4 && i < xq.size(); i++) begin
            checks++;
            if (xq[i] !== ed[i]) begin errors++; $display("FAIL wrap_dout %0d: got %h expected %h", i, xq[i], ed[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic e_rd;
        base_addr = 4'd3; len = 5'd4; loop_en = 1'b0;
        run(13, 3, 8, -1, -1);
        // Reads at 1,2,3 fill credit (2 in flight + 1 buffered); next read only
        // once ready returns and the buffer drains below 3.
        for (int c = 0; c < 13; c++) begin
            e_rd = (c >= 1 && c <= 3) || (c == 9);
            checks += 2;
            if (lg_rd[c] !== e_rd) begin errors++; $display("FAIL bp_rd c%0d: got %b expected %b", c, lg_rd[c], e_rd); end
            if (lg_done[c] !== (c == 11)) begin errors++; $display("FAIL bp_done c%0d: got %b expected %b", c, lg_done[c], c == 11); end
        end
        for (int c = 3; c < 8; c++) begin
            checks++;
            if (!(lg_dv[c] === 1'b1 && lg_dout[c] === 8'hA0)) begin
                errors++; $display("FAIL bp_stall_hold c%0d: got dv=%b dout=%h expected dv=1 dout=a0", c, lg_dv[c], lg_dout[c]);
            end
        end
        checks += 2;
        if (xq.size() != 4) begin errors++; $display("FAIL bp_nwords: got %0d expected 4", xq.size()); end
        if (lg_busy[12] !== 1'b0) begin errors++; $display("FAIL bp_busy_end: got %b expected 0", lg_busy[12]); end
        for (int i = 0; i < 4 && i < xq.size(); i++) begin
            checks++;
            if (xq[i] !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL bp_dout %0d: got %h expected %h", i, xq[i], 8'hA0 + 8'(i)); end
        end
        for (int i = 0; i < 4 && i < aq.size(); i++) begin
            checks++;
            if (aq[i] !== 4'(3 + i)) begin errors++; $display("FAIL bp_raddr %0d: got %0d expected %0d", i, aq[i], 3 + i); end
        end
    endtask

    task automatic test_loop();
        logic [NB_D-1:0] ed [3];
        logic [NB_A-1:0] ea [3];
        ed = '{8'hC2, 8'hA0, 8'hA1};
        ea = '{4'd2, 4'd3, 4'd4};
        base_addr = 4'd2; len = 5'd3; loop_en = 1'b1;
        run(15, -1, -1, 12, -1);
        checks++;
        if (xq.size() != 10) begin errors++; $display("FAIL loop_nwords: got %0d expected 10", xq.size()); end
        for (int i = 0; i < xq.size() && i < 10; i++) begin
            checks++;
            if (xq[i] !== ed[i % 3]) begin errors++; $display("FAIL loop_dout %0d: got %h expected %h", i, xq[i], ed[i % 3]); end
        end
        for (int c = 1; c <= 12; c++) begin
            checks++;
            if (!(lg_rd[c] === 1'b1 && lg_addr[c] === ea[(c - 1) % 3])) begin
                errors++; $display("FAIL loop_issue c%0d: got rd=%b addr=%0d expected rd=1 addr=%0d", c, lg_rd[c], lg_addr[c], ea[(c - 1) % 3]);
            end
        end
        for (int c = 0; c < 15; c++) begin
            checks++;
            if (lg_done[c] !== 1'b0) begin errors++; $display("FAIL loop_done c%0d: got %b expected 0", c, lg_done[c]); end
        end
        for (int c = 13; c < 15; c++) begin
            checks += 3;
            if (lg_dv[c] !== 1'b0) begin errors++; $display("FAIL stop_dv c%0d: got %b expected 0", c, lg_dv[c]); end
            if (lg_busy[c] !== 1'b0) begin errors++; $display("FAIL stop_busy c%0d: got %b expected 0", c, lg_busy[c]); end
            if (lg_rd[c] !== 1'b0) begin errors++; $display("FAIL stop_rd c%0d: got %b expected 0", c, lg_rd[c]); end
        end
        loop_en = 1'b0;
    endtask

    task automatic test_len0();
        base_addr = 4'd5; len = 5'd0; loop_en = 1'b0;
        run(3, -1, -1, -1, -1);
        for (int c = 0; c < 3; c++) begin
            checks += 3;
            if (lg_done[c] !== (c == 1)) begin errors++; $display("FAIL len0_done c%0d: got %b expected %b", c, lg_done[c], c == 1); end
            if (lg_rd[c] !== 1'b0) begin errors++; $display("FAIL len0_rd c%0d: got %b expected 0", c, lg_rd[c]); end
            if (lg_busy[c] !== 1'b0) begin errors++; $display("FAIL len0_busy c%0d: got %b expected 0", c, lg_busy[c]); end
        end
    endtask

    task automatic test_reset_mid();
        base_addr = 4'd3; len = 5'd4; loop_en = 1'b0;
        run(6, 3, 99, -1, -1);
        checks++;
        if (!(lg_busy[5] === 1'b1 && lg_dv[5] === 1'b1)) begin
            errors++; $display("FAIL rstmid_pre: got busy=%b dv=%b expected 1 1", lg_busy[5], lg_dv[5]);
        end
        #1 rst = 1'b1;
        #1;
        checks += 6;
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b expected 0", done); end
        if (bus.rd !== 1'b0) begin errors++; $display("FAIL rstmid_rd: got %b expected 0", bus.rd); end
        if (bus.raddr !== 4'h0) begin errors++; $display("FAIL rstmid_raddr: got %h expected 0", bus.raddr); end
        if (bus.dout !== 8'h00) begin errors++; $display("FAIL rstmid_dout: got %h expected 00", bus.dout); end
        if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL rstmid_dv: got %b expected 0", bus.dout_valid); end
        @(negedge clk);
        rst = 1'b0;
        run(9, -1, -1, -1, -1);
        checks += 3;
        if (lg_dv[2] !== 1'b0) begin errors++; $display("FAIL rstmid_first_early: got %b expected 0", lg_dv[2]); end
        if (lg_dv[3] !== 1'b1) begin errors++; $display("FAIL rstmid_first: got %b expected 1", lg_dv[3]); end
        if (xq.size() != 4) begin errors++; $display("FAIL rstmid_nwords: got %0d expected 4", xq.size()); end
        for (int i = 0; i < 4 && i < xq.size(); i++) begin
            checks++;
            if (xq[i] !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL rstmid_dout %0d: got %h expected %h", i, xq[i], 8'hA0 + 8'(i)); end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 8'hC0 | 8'(i);
        ram[3] = 8'hA0; ram[4] = 8'hA1; ram[5] = 8'hA2; ram[6] = 8'hA3;
        bus.dout_ready = 1'b1;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_loop();
        test_len0();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
